multicycle_controller: RTL

//  Multicycle sequencer for the RV32I datapath: one shared ALU/memory reused across FETCH..WRITEBACK states.

---
 rtl/multicycle_controller_if.sv | 39 +++
 rtl/multicycle_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and memory status in, datapath selects/enables out.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
    parameter int INSTRET_W = 32
) ();
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 adr_src;
    logic                 mem_req;
    logic                 mem_write;
    logic                 ir_write;
    logic [1:0]           result_src;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           imm_src;
    logic [2:0]           alu_control;
    logic                 reg_write;
    logic                 illegal_instr;
    logic                 mem_timeout;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, reg_write,
               illegal_instr, mem_timeout, instret
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, reg_write,
               illegal_instr, mem_timeout, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer driving a shared ALU/memory datapath from FETCH through writeback.
// Latency: 3-5 states per instruction plus memory wait; selects are registered from the next state.
// Backpressure: mem_req held until mem_ready; MEM_TIMEOUT consecutive waits halt the core.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
    } ctrl_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int             CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t               state;
    state_t               nxt;
    ctrl_t                ctrl_q;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 illegal_q;
    logic                 timeout_q;
    logic [INSTRET_W-1:0] instret_q;

    logic       alu_legal;
    logic [2:0] alu_op;
    logic       br_legal;
    logic       br_take;
    logic       mem_state;
    logic       timed_out;
    logic       illegal_now;
    logic       retire;

    always_comb begin
        alu_legal = 1'b1;
        alu_op    = ALU_ADD;
        case (bus.funct3)
            3'b000:  alu_op = (bus.opcode == OP_R && bus.funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_legal = 1'b0;
        endcase
    end

    // funct3[0] selects bne, which inverts the zero flag.
    assign br_legal = (bus.funct3[2:1] == 2'b00);
    assign br_take  = br_legal & (bus.zero ^ bus.funct3[0]);

    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timed_out = mem_state && !bus.mem_ready && (wait_cnt == CNT_LAST);

    always_comb begin
        nxt         = state;
        illegal_now = 1'b0;
        case (state)
            S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_R:         nxt = S_EXECR;
                    OP_I:         nxt = S_EXECI;
                    OP_B:         nxt = S_BEQ;
                    OP_JAL:       nxt = S_JAL;
                    default: begin
                        nxt         = S_HALT;
                        illegal_now = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   nxt = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) nxt = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) nxt = S_FETCH;
            S_MEMWB:    nxt = S_FETCH;
            S_EXECR, S_EXECI: begin
                nxt         = alu_legal ? S_ALUWB : S_HALT;
                illegal_now = !alu_legal;
            end
            S_ALUWB:    nxt = S_FETCH;
            S_BEQ: begin
                nxt         = br_legal ? S_FETCH : S_HALT;
                illegal_now = !br_legal;
            end
            S_JAL:      nxt = S_ALUWB;
            default:    nxt = S_HALT;
        endcase
        if (timed_out) nxt = S_HALT;
    end

    // Every path back into FETCH from another state completes an instruction.
    assign retire = (nxt == S_FETCH) && (state != S_FETCH);

    function automatic ctrl_t decode(input state_t s, input logic [6:0] op, input logic [2:0] aop);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 2'b10;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = aop;
            end
            S_EXECI: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b01;
                c.alu_control = aop;
            end
            S_ALUWB:  c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = ALU_SUB;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.imm_src   = 2'b11;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_FETCH;
            ctrl_q    <= decode(S_FETCH, bus.opcode, alu_op);
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state  <= nxt;
            ctrl_q <= decode(nxt, bus.opcode, alu_op);
            if (nxt != state || bus.mem_ready) begin
                wait_cnt <= '0;
            end else if (mem_state) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (illegal_now) illegal_q <= 1'b1;
            if (timed_out)   timeout_q <= 1'b1;
            if (retire)      instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // The fetch handshake and branch decision are the only paths that see inputs combinationally.
    assign bus.ir_write    = rst & (state == S_FETCH) & bus.mem_ready;
    assign bus.pc_write    = rst & (ctrl_q.pc_write
                                    | ((state == S_FETCH) & bus.mem_ready)
                                    | ((state == S_BEQ) & br_take));
    assign bus.mem_req     = rst & ctrl_q.mem_req;
    assign bus.mem_write   = rst & ctrl_q.mem_write;
    assign bus.adr_src     = rst & ctrl_q.adr_src;
    assign bus.reg_write   = rst & ctrl_q.reg_write;
    assign bus.result_src  = rst ? ctrl_q.result_src  : 2'b00;
    assign bus.alu_src_a   = rst ? ctrl_q.alu_src_a   : 2'b00;
    assign bus.alu_src_b   = rst ? ctrl_q.alu_src_b   : 2'b00;
    assign bus.imm_src     = rst ? ctrl_q.imm_src     : 2'b00;
    assign bus.alu_control = rst ? ctrl_q.alu_control : 3'b000;
    assign bus.illegal_instr = illegal_q;
    assign bus.mem_timeout   = timeout_q;
    assign bus.instret       = instret_q;
endmodule
